uart_rx_mmio: RTL and testbench
===============================

// Module: uart_rx_mmio
// PURPOSE
//  Receive side of the board serial link: samples rxd, deframes 8-bit async characters,
//  buffers them in a small FIFO and presents them to the retro CPU as two read-only
//  memory-mapped registers (data, status). Sits beside the TX path in the top level and
//  shares the CPU address bus. A data read pops one byte.
// PARAMETERS
//  ADDRESS_WIDTH  16       CPU address bus width
//  BIT_CYCLES     104      clk cycles per bit (12 MHz / 115200)
//  FIFO_DEPTH     8        receive FIFO entries, power of two, >= 2
//  DATA_ADDR      16'hFFFE read = pop oldest byte
//  STAT_ADDR      16'hFFFD read = status
// PORTS
//  clk       in   1              system clock
//  rstb      in   1              asynchronous active-low reset
//  rxd       in   1              serial rx data, asynchronous, idle high
//  address   in   ADDRESS_WIDTH  CPU address
//  rden      in   1              CPU read strobe, sampled on posedge clk
//  rdata     out  8              read data, combinational from address/state
//  sel       out  1              1 when address == DATA_ADDR or STAT_ADDR
//  rx_avail  out  1              FIFO not empty (registered)
// BEHAVIOUR
//  Reset (rstb=0, async): FSM IDLE, FIFO empty, all sticky flags 0, sync flops 1;
//   rx_avail=0; rdata=0 for status/empty-data reads. Reset mid-frame drops the frame.
//  rxd passes a 2-flop synchroniser (reset 1); all logic uses the synced value.
//  FSM: IDLE -> START on synced rxd==0; START waits BIT_CYCLES/2, rxd==1 -> IDLE (glitch,
//   no flag), else -> DATA; DATA samples 8 bits LSB first, one every BIT_CYCLES at bit
//   centre; -> STOP (or PARITY with macro); STOP samples at centre:
//   1 -> push byte, IDLE; 0 -> discard byte, set ferr, BREAK; BREAK waits rxd==1 -> IDLE.
//  Bit counter 3-bit, cycle counter sized $clog2(BIT_CYCLES); counter reset on each state entry.
//  Push occurs the cycle after stop-bit centre sample; rx_avail rises the next cycle.
//  FIFO full at push: byte dropped, ovr set, contents unchanged.
//  Push and pop same cycle: both act; at full this is not overrun; at empty pop is ignored
//   and the push lands.
//  rdata: address==DATA_ADDR -> FIFO head (0x00 if empty); address==STAT_ADDR ->
//   {4'b0, perr, ferr, ovr, avail}; else 0x00.
//  rden && address==DATA_ADDR && !empty -> pop at that edge; read of empty FIFO no effect.
//  rden && address==STAT_ADDR -> clears ovr/ferr/perr at that edge; an event in the same
//   cycle wins (flag stays set).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples bit 9; even-parity
//   mismatch sets perr; byte still pushed. Stop check as above.
//  Undefined: frame 8N1, no PARITY state, perr bit reads constant 0.
// STRUCTURE
//  uart_pkg.vh: state encodings (IDLE/START/DATA/PARITY/STOP/BREAK), status bit positions,
//   default DATA_ADDR/STAT_ADDR.
//  Sub-module rx_fifo (DEPTH, WIDTH=8): push/pop/full/empty/head, wrap-around pointers with
//   extra MSB for full/empty; FSM and register decode stay in uart_rx_mmio.
// TESTING (BIT_CYCLES=16 for sim)
//  Send 0x55 8N1 -> rx_avail=1 ~161 cycles after start edge; read STAT -> 0x01; read DATA
//   -> 0x55, then rx_avail=0, STAT=0x00.
//  rxd low pulse of 4 cycles -> FSM back to IDLE, no push, STAT=0x00.
//  Stop bit forced 0 on 0xA3 -> no push, STAT=0x04; rxd held low 100 cycles then high ->
//   next frame 0x12 received; STAT read clears ferr.
//  Send 9 bytes 0x01..0x09 with no reads (DEPTH=8) -> STAT=0x03; reads return 0x01..0x08
//   then empty read returns 0x00 and rx_avail stays 0.
//  Full FIFO, DATA read coincident with 9th push cycle -> no ovr, last entry = 9th byte.
//  With UART_RX_PARITY_EN: 0x07 with parity 0 -> byte pushed, STAT=0x09; rstb low mid-frame
//   -> FIFO empty, STAT=0x00, next frame received clean.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// rtl/uart_rx_mmio_pkg.sv - shared state encodings, status layout and default addresses for the UART receiver
package uart_rx_mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int STAT_AVAIL_BIT = 0;
    localparam int STAT_OVR_BIT   = 1;
    localparam int STAT_FERR_BIT  = 2;
    localparam int STAT_PERR_BIT  = 3;

    localparam logic [15:0] DEF_DATA_ADDR = 16'hFFFE;
    localparam logic [15:0] DEF_STAT_ADDR = 16'hFFFD;

    function automatic logic [7:0] stat_byte(input logic perr, input logic ferr,
                                             input logic ovr, input logic avail);
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_PERR_BIT]  = perr;
        s[STAT_FERR_BIT]  = ferr;
        s[STAT_OVR_BIT]   = ovr;
        s[STAT_AVAIL_BIT] = avail;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// rtl/uart_rx_mmio_if.sv - CPU read-bus bundle between the retro CPU and the UART receive registers
interface uart_rx_mmio_if #(
    parameter int ADDRESS_WIDTH = 16
) ();
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     rden;
    logic [7:0]               rdata;
    logic                     sel;

    modport master (output address, output rden, input rdata, input sel);
    modport slave  (input address, input rden, output rdata, output sel);
endinterface

// File: rtl/uart_rx_mmio_rx_fifo.sv
// rtl/uart_rx_mmio_rx_fifo.sv - receive byte FIFO with wrap-around pointers and an extra MSB for full/empty
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign wr_en = push && (!full || rd_en);
    assign head  = empty ? '0 : mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - UART receiver with FIFO and read-only data/status registers on the CPU bus
// Optional even-parity (8E1) framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       BIT_CYCLES    = 104,
    parameter int                       FIFO_DEPTH    = 8,
    parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDR     = ADDRESS_WIDTH'(DEF_DATA_ADDR),
    parameter logic [ADDRESS_WIDTH-1:0] STAT_ADDR     = ADDRESS_WIDTH'(DEF_STAT_ADDR)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 rxd,
    uart_rx_mmio_if.slave        bus,
    output logic                 rx_avail
);
    localparam int            CW       = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2 - 1);

    logic            rxd_m, rxd_s;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cyc_q;
    logic [2:0]      bit_q;
    logic [7:0]      shreg_q;
    logic            push_q;
    logic            data_smp, stop_ok, ferr_evt;
    logic            full, empty, pop, ovr_evt;
    logic [7:0]      head;
    logic            is_data, is_stat, stat_rd;
    logic            ovr_q, ferr_q, perr_bit;
    logic [7:0]      rdata_c;
`ifdef UART_RX_PARITY_EN
    logic            perr_evt, perr_q;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_smp = 1'b0;
        stop_ok  = 1'b0;
        ferr_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_evt = 1'b0;
`endif
        case (state_q)
            ST_IDLE:  if (!rxd_s) state_d = ST_START;
            ST_START: if (cyc_q == CYC_HALF) state_d = rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (cyc_q == CYC_LAST) begin
                    data_smp = 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (cyc_q == CYC_LAST) begin
`ifdef UART_RX_PARITY_EN
                    perr_evt = ((^shreg_q) != rxd_s);
`endif
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cyc_q == CYC_LAST) begin
                    if (rxd_s) begin
                        stop_ok = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_evt = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: if (rxd_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Cycle counter restarts on every state entry and after each data sample, so
    // samples fall at bit centres relative to the half-bit point found in START.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            push_q  <= stop_ok;
            if (state_d != state_q || data_smp) cyc_q <= '0;
            else                                cyc_q <= cyc_q + CW'(1);
            if (state_d != state_q) bit_q <= 3'd0;
            else if (data_smp)      bit_q <= bit_q + 3'd1;
            if (data_smp) shreg_q <= {rxd_s, shreg_q[7:1]};
        end
    end

    assign is_data = (bus.address == DATA_ADDR);
    assign is_stat = (bus.address == STAT_ADDR);
    assign stat_rd = bus.rden && is_stat;
    assign pop     = bus.rden && is_data && !empty;
    assign ovr_evt = push_q && full && !pop;

    rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (push_q),
        .pop   (pop),
        .wdata (shreg_q),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // A flag-setting event in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            rx_avail <= 1'b0;
        end else begin
            ovr_q    <= ovr_evt  | (ovr_q  & ~stat_rd);
            ferr_q   <= ferr_evt | (ferr_q & ~stat_rd);
            rx_avail <= !empty;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) perr_q <= 1'b0;
        else       perr_q <= perr_evt | (perr_q & ~stat_rd);
    end
    assign perr_bit = perr_q;
`else
    assign perr_bit = 1'b0;
`endif

    always_comb begin
        rdata_c = 8'h00;
        if (is_data)      rdata_c = head;
        else if (is_stat) rdata_c = stat_byte(perr_bit, ferr_q, ovr_q, !empty);
    end

    assign bus.rdata = rdata_c;
    assign bus.sel   = is_data || is_stat;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - scoreboard bench for uart_rx_mmio with directed serial frames and CPU reads
module tb_uart_rx_mmio;
    localparam int          BITC = 16;
    localparam logic [15:0] DA   = 16'hFFFE;
    localparam logic [15:0] SA   = 16'hFFFD;

    logic clk = 1'b0;
    logic rstb;
    logic rxd;
    logic rx_avail;

    uart_rx_mmio_if #(.ADDRESS_WIDTH(16)) bus ();

    uart_rx_mmio #(
        .ADDRESS_WIDTH (16),
        .BIT_CYCLES    (BITC),
        .FIFO_DEPTH    (8),
        .DATA_ADDR     (DA),
        .STAT_ADDR     (SA)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .rxd      (rxd),
        .bus      (bus),
        .rx_avail (rx_avail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sel;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat    = 0;

    // Monitor: every strobed read is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rden === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: got rdata=%02h with no expectation queued", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rdata !== e.data || bus.sel !== e.sel) begin
                        n_fail++;
                        $display("FAIL %s: got rdata=%02h sel=%b, want rdata=%02h sel=%b",
                                 e.name, bus.rdata, bus.sel, e.data, e.sel);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] d, input logic s, input string nm);
        exp_q.push_back('{d, s, nm});
        bus.address = a;
        bus.rden    = 1'b1;
        cycles(1);
        bus.rden    = 1'b0;
        bus.address = 16'h0000;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        cycles(BITC);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
        if (stop) cycles(4);
    endtask

    initial begin
        logic in_win;
        rstb        = 1'b0;
        rxd         = 1'b1;
        bus.rden    = 1'b0;
        bus.address = 16'h0000;
        cycles(5);
        rstb = 1'b1;
        cycles(5);

        // Reset state and address decode
        check("reset_rx_avail", 32'(rx_avail), 32'd0);
        cpu_read(SA, 8'h00, 1'b1, "reset_stat");
        cpu_read(DA, 8'h00, 1'b1, "reset_data_empty");
        cpu_read(16'h1234, 8'h00, 1'b0, "unmapped_read");

        // 0x55: latency from start edge to rx_avail
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                while (rx_avail !== 1'b1 && lat < 400) begin
                    cycles(1);
                    lat++;
                end
            end
        join
        in_win = (lat >= 145 && lat <= 175);
        check("avail_latency_window", 32'(in_win), 32'd1);
        if (!in_win) $display("latency measured %0d cycles", lat);
        cpu_read(SA, 8'h01, 1'b1, "stat_after_55");
        cpu_read(DA, 8'h55, 1'b1, "data_55");
        cycles(2);
        check("rx_avail_after_pop", 32'(rx_avail), 32'd0);
        cpu_read(SA, 8'h00, 1'b1, "stat_after_pop");

        // Short low glitch is rejected in START
        rxd = 1'b0;
        cycles(4);
        rxd = 1'b1;
        cycles(200);
        check("glitch_no_push", 32'(rx_avail), 32'd0);
        cpu_read(SA, 8'h00, 1'b1, "stat_after_glitch");

        // Framing error, break, recovery
        send_frame(8'hA3, 1'b0);
        cycles(100);
        cpu_read(SA, 8'h04, 1'b1, "stat_ferr");
        rxd = 1'b1;
        cycles(20);
        send_frame(8'h12, 1'b1);
        cpu_read(SA, 8'h01, 1'b1, "stat_after_break");
        cpu_read(DA, 8'h12, 1'b1, "data_12_after_break");
        cpu_read(SA, 8'h00, 1'b1, "stat_ferr_cleared");

        // Overrun: 9 bytes into 8 entries
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        cpu_read(SA, 8'h03, 1'b1, "stat_ovr");
        cpu_read(SA, 8'h01, 1'b1, "stat_ovr_cleared");
        for (int i = 1; i <= 8; i++) cpu_read(DA, 8'(i), 1'b1, $sformatf("ovr_data_%0d", i));
        cpu_read(DA, 8'h00, 1'b1, "ovr_empty_read");
        cycles(2);
        check("rx_avail_after_drain", 32'(rx_avail), 32'd0);

        // Pop coincident with push at full: not an overrun
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1);
        fork
            send_frame(8'h19, 1'b1);
            begin
                cycles(lat - 2);
                cpu_read(DA, 8'h11, 1'b1, "coincident_pop");
            end
        join
        cpu_read(SA, 8'h01, 1'b1, "coincident_no_ovr");
        for (int i = 1; i < 8; i++) cpu_read(DA, 8'h11 + 8'(i), 1'b1, $sformatf("coin_data_%0d", i));
        cpu_read(DA, 8'h19, 1'b1, "coin_last_is_9th");
        cpu_read(DA, 8'h00, 1'b1, "coin_empty");

`ifdef UART_RX_PARITY_EN
        // 0x07 carries odd weight; a 0 parity bit is a mismatch but the byte is kept
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h07 >> i) & 8'h01) != 8'h00);
        send_bit(1'b0);
        send_bit(1'b1);
        cycles(4);
        cpu_read(SA, 8'h09, 1'b1, "stat_perr");
        cpu_read(DA, 8'h07, 1'b1, "data_07_perr");
        cpu_read(SA, 8'h00, 1'b1, "stat_perr_cleared");
`endif

        // Reset mid-frame empties FIFO and drops the partial frame
        send_frame(8'h21, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rstb = 1'b0;
        cycles(2);
        rxd  = 1'b1;
        rstb = 1'b1;
        cycles(20);
        check("rx_avail_after_reset", 32'(rx_avail), 32'd0);
        cpu_read(SA, 8'h00, 1'b1, "stat_after_reset");
        cpu_read(DA, 8'h00, 1'b1, "data_after_reset");
        send_frame(8'h34, 1'b1);
        cpu_read(SA, 8'h01, 1'b1, "stat_after_reset_frame");
        cpu_read(DA, 8'h34, 1'b1, "data_34_after_reset");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycles(1);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
